// File: rtl/rgb_pkg.sv
// ---------------------------------------------------------------------------
// rgb_pkg
// Shared definitions for the LED serial bit protocol (transmit and receive
// paths):
//   - tx_state_e  : transmit FSM state encoding
//   - *_NUM_BITS  : word lengths for RGB and RGBW LEDs
//   - *_DEF       : default pulse timings in clocks at 96 MHz. The receive
//                   path also uses them as decision thresholds.
//   - max_int     : constant helper used when sizing counters
// ---------------------------------------------------------------------------
package rgb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_SRST = 2'd3
  } tx_state_e;

  localparam int RGB_NUM_BITS  = 24;
  localparam int RGBW_NUM_BITS = 32;

  // About 0.3 us, 0.6 us, 1.25 us and 80 us at 96 MHz.
  localparam int T0H_CLKS_DEF          = 29;
  localparam int T1H_CLKS_DEF          = 58;
  localparam int TBIT_CLKS_DEF         = 120;
  localparam int STREAM_RESET_CLKS_DEF = 7680;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rgb_bit_timer.sv
// ---------------------------------------------------------------------------
// rgb_bit_timer
// Loadable down-counter that times a single line phase. The phase is a high
// time, a low time, or a stream reset.
//   clk, rst  : clock, asynchronous active-low reset
//   load      : start a new phase of 'duration' clocks
//   duration  : phase length in clocks (must be >= 1)
//   expired   : high on the last clock of the phase
// A load stores duration-1. 'expired' is therefore asserted on exactly the
// duration-th clock after the loading edge.
// ---------------------------------------------------------------------------
module rgb_bit_timer #(
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] duration,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload on phase entry, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = duration - CNT_W'(1);
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/rgbw_wrd2sbit_tx.sv
// ---------------------------------------------------------------------------
// rgbw_wrd2sbit_tx
// Serialises parallel LED words (MSB first) into the one-wire NRZ
// pulse-width line for SK6812/WS2812-class LEDs. It can also emit stream
// resets (the line held low). A one-entry holding buffer lets a following
// item start on the same edge the current one ends, so there is no gap.
//   clk              : system clock
//   rst              : asynchronous active-low reset
//   in_strobe        : offer an item; accepted when out_ready=1
//   in_word          : LED word, sampled on accept
//   in_stream_reset  : sampled on accept; 1 = item is a stream reset
//   out_ready        : holding buffer empty
//   out_serial       : registered LED data line
//   out_busy         : a word or a stream reset is in progress
//   out_done         : one-clock pulse after an item finishes
//   out_overflow     : sticky; an item was offered while the buffer was full
// ---------------------------------------------------------------------------
module rgbw_wrd2sbit_tx
  import rgb_pkg::*;
#(
  parameter int NUM_BITS          = RGBW_NUM_BITS,
  parameter int T0H_CLKS          = T0H_CLKS_DEF,
  parameter int T1H_CLKS          = T1H_CLKS_DEF,
  parameter int TBIT_CLKS         = TBIT_CLKS_DEF,
  parameter int STREAM_RESET_CLKS = STREAM_RESET_CLKS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_strobe,
  input  logic [NUM_BITS-1:0] in_word,
  input  logic                in_stream_reset,
  output logic                out_ready,
  output logic                out_serial,
  output logic                out_busy,
  output logic                out_done,
  output logic                out_overflow
);

  localparam int CNT_W = $clog2(max_int(TBIT_CLKS, STREAM_RESET_CLKS) + 1);
  localparam int BIT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  localparam logic [CNT_W-1:0] T0H_LD  = CNT_W'(T0H_CLKS);
  localparam logic [CNT_W-1:0] T1H_LD  = CNT_W'(T1H_CLKS);
  localparam logic [CNT_W-1:0] T0L_LD  = CNT_W'(TBIT_CLKS - T0H_CLKS);
  localparam logic [CNT_W-1:0] T1L_LD  = CNT_W'(TBIT_CLKS - T1H_CLKS);
  localparam logic [CNT_W-1:0] SRST_LD = CNT_W'(STREAM_RESET_CLKS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NUM_BITS - 1);

  tx_state_e           state_q,     state_d;
  logic                buf_valid_q, buf_valid_d;
  logic [NUM_BITS-1:0] buf_word_q,  buf_word_d;
  logic                buf_srst_q,  buf_srst_d;
  logic [NUM_BITS-1:0] shift_q,     shift_d;
  logic [BIT_W-1:0]    bit_cnt_q,   bit_cnt_d;
  logic                serial_q,    serial_d;
  logic                done_q,      done_d;
  logic                overflow_q,  overflow_d;

  logic                accept_s;
  logic                consume_s;
  logic                item_end_s;
  logic                timer_load_s;
  logic [CNT_W-1:0]    timer_dur_s;
  logic                timer_expired_s;

  rgb_bit_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load_s),
    .duration (timer_dur_s),
    .expired  (timer_expired_s)
  );

  // Next-state logic: bit phases, buffer fill/drain, line value and status.
  always_comb begin
    state_d      = state_q;
    buf_valid_d  = buf_valid_q;
    buf_word_d   = buf_word_q;
    buf_srst_d   = buf_srst_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    serial_d     = serial_q;
    done_d       = 1'b0;
    overflow_d   = overflow_q | (in_strobe & buf_valid_q);
    timer_load_s = 1'b0;
    timer_dur_s  = {CNT_W{1'b0}};
    item_end_s   = 1'b0;
    consume_s    = 1'b0;
    accept_s     = in_strobe & ~buf_valid_q;

    case (state_q)
      ST_IDLE: begin
        serial_d = 1'b0;
      end
      ST_HIGH: begin
        if (timer_expired_s) begin
          // The low time complements the high time, so every bit is TBIT long.
          state_d      = ST_LOW;
          serial_d     = 1'b0;
          timer_load_s = 1'b1;
          timer_dur_s  = shift_q[NUM_BITS-1] ? T1L_LD : T0L_LD;
        end else begin
          serial_d = 1'b1;
        end
      end
      ST_LOW: begin
        if (timer_expired_s) begin
          if (bit_cnt_q == LAST_BIT) begin
            item_end_s = 1'b1;
          end else begin
            // The next bit's high time is taken from the bit about to become MSB.
            state_d      = ST_HIGH;
            serial_d     = 1'b1;
            shift_d      = {shift_q[NUM_BITS-2:0], 1'b0};
            bit_cnt_d    = bit_cnt_q + BIT_W'(1);
            timer_load_s = 1'b1;
            timer_dur_s  = shift_q[NUM_BITS-2] ? T1H_LD : T0H_LD;
          end
        end else begin
          serial_d = 1'b0;
        end
      end
      ST_SRST: begin
        if (timer_expired_s) begin
          item_end_s = 1'b1;
        end else begin
          serial_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        serial_d = 1'b0;
      end
    endcase

    // The buffer is drained in IDLE, or directly at the end of an item.
    // Draining at the end of an item keeps back-to-back items gap-free.
    consume_s = buf_valid_q & ((state_q == ST_IDLE) | item_end_s);
    done_d    = item_end_s;

    if (consume_s) begin
      buf_valid_d  = 1'b0;
      shift_d      = buf_word_q;
      bit_cnt_d    = {BIT_W{1'b0}};
      timer_load_s = 1'b1;
      if (buf_srst_q) begin
        state_d     = ST_SRST;
        serial_d    = 1'b0;
        timer_dur_s = SRST_LD;
      end else begin
        state_d     = ST_HIGH;
        serial_d    = 1'b1;
        timer_dur_s = buf_word_q[NUM_BITS-1] ? T1H_LD : T0H_LD;
      end
    end else if (item_end_s) begin
      state_d  = ST_IDLE;
      serial_d = 1'b0;
    end else begin
      // Mid-item: the case statement already chose the next phase.
    end

    // accept_s needs an empty buffer and consume_s needs a full one, so the
    // two are never true together.
    if (accept_s) begin
      buf_valid_d = 1'b1;
      buf_word_d  = in_word;
      buf_srst_d  = in_stream_reset;
    end else begin
      // An offer to a full buffer is dropped and only sets overflow.
    end
  end

  // State, buffer, shifter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      buf_valid_q <= 1'b0;
      buf_word_q  <= {NUM_BITS{1'b0}};
      buf_srst_q  <= 1'b0;
      shift_q     <= {NUM_BITS{1'b0}};
      bit_cnt_q   <= {BIT_W{1'b0}};
      serial_q    <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_word_q  <= buf_word_d;
      buf_srst_q  <= buf_srst_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      serial_q    <= serial_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_ready    = ~buf_valid_q;
  assign out_serial   = serial_q;
  assign out_busy     = (state_q != ST_IDLE);
  assign out_done     = done_q;
  assign out_overflow = overflow_q;

endmodule

// File: tb/tb_rgbw_wrd2sbit_tx.sv
// ---------------------------------------------------------------------------
// tb_rgbw_wrd2sbit_tx
// Directed bench for the LED word-to-serial transmitter. A negedge monitor
// logs the clock index of every line rise, line fall and done pulse.
// Each scenario then decodes the logged pulses back into words and timings
// and compares them with hand-computed values.
// ---------------------------------------------------------------------------
module tb_rgbw_wrd2sbit_tx;

  localparam int NB   = 32;
  localparam int T0H  = 29;
  localparam int T1H  = 58;
  localparam int TBIT = 120;
  localparam int SRST = 7680;
  localparam int WCLK = NB * TBIT;   // 3840 clocks per word

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_strobe = 1'b0;
  logic [31:0] in_word = 32'd0;
  logic        in_stream_reset = 1'b0;
  logic        out_ready, out_serial, out_busy, out_done, out_overflow;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int rise_q[$];
  int fall_q[$];
  int done_q[$];
  logic prev_ser = 1'b0;

  rgbw_wrd2sbit_tx dut (
    .clk             (clk),
    .rst             (rst),
    .in_strobe       (in_strobe),
    .in_word         (in_word),
    .in_stream_reset (in_stream_reset),
    .out_ready       (out_ready),
    .out_serial      (out_serial),
    .out_busy        (out_busy),
    .out_done        (out_done),
    .out_overflow    (out_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log, sampled on the inactive edge.
  always @(negedge clk) begin
    if (out_serial && !prev_ser) rise_q.push_back(cyc);
    if (!out_serial && prev_ser) fall_q.push_back(cyc);
    if (out_done) done_q.push_back(cyc);
    prev_ser = out_serial;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  function automatic logic [31:0] status_vec();
    return {27'd0, out_serial, out_ready, out_busy, out_done, out_overflow};
  endfunction

  task automatic clear_log();
    rise_q.delete();
    fall_q.delete();
    done_q.delete();
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!out_busy && out_ready) ok = 1'b1;
    end
    check_eq({tag, " idle"}, 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Offer one item once the buffer is free; returns the accepting edge index.
  task automatic offer(input logic [31:0] w, input logic s, output int acc);
    for (int i = 0; i < 20000 && !out_ready; i++) begin
      @(posedge clk);
      #1;
    end
    in_strobe       = 1'b1;
    in_word         = w;
    in_stream_reset = s;
    @(posedge clk);
    #1;
    acc             = cyc;
    in_strobe       = 1'b0;
    in_stream_reset = 1'b0;
  endtask

  // Rebuild a word from its logged high widths and check the bit periods.
  task automatic verify_word(input string tag, input int base, input logic [31:0] exp);
    logic [31:0] w;
    int hi, bad_hi, bad_per;
    w = 32'd0;
    bad_hi = 0;
    bad_per = 0;
    if (base + NB > rise_q.size() || base + NB > fall_q.size()) begin
      bad_hi = NB;
    end else begin
      for (int i = 0; i < NB; i++) begin
        hi = fall_q[base + i] - rise_q[base + i];
        if (hi == T1H) w[NB - 1 - i] = 1'b1;
        else if (hi != T0H) bad_hi++;
        if (i < NB - 1 && (rise_q[base + i + 1] - rise_q[base + i]) != TBIT) bad_per++;
      end
    end
    check_eq({tag, " bits"}, w, exp);
    check_eq({tag, " bad high widths"}, 32'(bad_hi), 32'd0);
    check_eq({tag, " bad bit periods"}, 32'(bad_per), 32'd0);
  endtask

  initial begin
    int a, a2, r0;

    // Reset values while rst is held low.
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset status", status_vec(), 32'h0000_0008);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single word: latency, bit timing, done timing.
    clear_log();
    offer(32'hA500_0000, 1'b0, a);
    check_eq("t1 line low on accept", 32'(out_serial), 32'd0);
    wait_idle(6000, "t1");
    r0 = q_at(rise_q, 0);
    check_eq("t1 first rise", 32'(r0), 32'(a + 1));
    verify_word("t1", 0, 32'hA500_0000);
    check_eq("t1 done count", 32'(done_q.size()), 32'd1);
    check_eq("t1 done time", 32'(q_at(done_q, 0)), 32'(r0 + WCLK));

    // Back-to-back words: no gap; ready follows the buffer.
    clear_log();
    offer(32'hFFFF_FFFF, 1'b0, a);
    offer(32'h0000_0000, 1'b0, a2);
    check_eq("t2 ready full", 32'(out_ready), 32'd0);
    wait_to(a + 1 + WCLK - 1);
    check_eq("t2 ready held", 32'(out_ready), 32'd0);
    wait_to(a + 1 + WCLK);
    check_eq("t2 ready drained", 32'(out_ready), 32'd1);
    wait_idle(9000, "t2");
    check_eq("t2 rise count", 32'(rise_q.size()), 32'd64);
    check_eq("t2 word2 start", 32'(q_at(rise_q, 32)), 32'(a + 1 + WCLK));
    verify_word("t2 w1", 0, 32'hFFFF_FFFF);
    verify_word("t2 w2", 32, 32'h0000_0000);
    check_eq("t2 done count", 32'(done_q.size()), 32'd2);

    // Stream reset followed by a word.
    clear_log();
    offer(32'h0000_0000, 1'b1, a);
    offer(32'h8000_0000, 1'b0, a2);
    wait_idle(12000, "t3");
    check_eq("t3 first rise", 32'(q_at(rise_q, 0)), 32'(a + 1 + SRST));
    check_eq("t3 done count", 32'(done_q.size()), 32'd2);
    check_eq("t3 srst done", 32'(q_at(done_q, 0)), 32'(a + 1 + SRST));
    check_eq("t3 word done", 32'(q_at(done_q, 1)), 32'(a + 1 + SRST + WCLK));
    verify_word("t3", 0, 32'h8000_0000);

    // Accept on the final-bit edge with an empty buffer: one IDLE clock.
    clear_log();
    offer(32'h0F0F_0F0F, 1'b0, a);
    r0 = a + 1;
    wait_to(r0 + WCLK - 1);
    in_strobe = 1'b1;
    in_word   = 32'hF0F0_F0F0;
    @(posedge clk);
    #1;
    in_strobe = 1'b0;
    check_eq("t4 gap idle", 32'(out_busy), 32'd0);
    check_eq("t4 buffer full", 32'(out_ready), 32'd0);
    wait_idle(9000, "t4");
    check_eq("t4 word2 start", 32'(q_at(rise_q, 32)), 32'(r0 + WCLK + 1));
    verify_word("t4 w1", 0, 32'h0F0F_0F0F);
    verify_word("t4 w2", 32, 32'hF0F0_F0F0);

    // Overflow: burst of three strobes while a word is transmitting.
    // The buffer takes the first; the other two find it full and are dropped.
    clear_log();
    offer(32'hC300_0000, 1'b0, a);
    wait_to(a + 5);
    check_eq("t5 no overflow yet", 32'(out_overflow), 32'd0);
    in_strobe = 1'b1;
    in_word   = 32'h3C00_FF00;
    @(posedge clk);
    #1;
    in_word   = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    in_word   = 32'h1234_5678;
    @(posedge clk);
    #1;
    in_strobe = 1'b0;
    check_eq("t5 overflow set", 32'(out_overflow), 32'd1);
    wait_idle(9000, "t5");
    check_eq("t5 overflow sticky", 32'(out_overflow), 32'd1);
    check_eq("t5 rise count", 32'(rise_q.size()), 32'd64);
    check_eq("t5 done count", 32'(done_q.size()), 32'd2);
    verify_word("t5 w1", 0, 32'hC300_0000);
    verify_word("t5 w2", 32, 32'h3C00_FF00);

    // Asynchronous reset while bit 5 is high, then a clean word.
    clear_log();
    offer(32'hA500_0000, 1'b0, a);
    r0 = a + 1;
    wait_to(r0 + 5 * TBIT + 10);
    check_eq("t6 line high", 32'(out_serial), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6 async reset", status_vec(), 32'h0000_0008);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    offer(32'h1234_5678, 1'b0, a);
    wait_idle(6000, "t6");
    check_eq("t6 first rise", 32'(q_at(rise_q, 0)), 32'(a + 1));
    verify_word("t6", 0, 32'h1234_5678);
    check_eq("t6 done count", 32'(done_q.size()), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
